// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module     : morse_decoder
// Description: Serial Morse receiver. Samples a mark/space line once per
//              tick, builds dot/dash elements and decodes letters A..H.
// Revision   : 1.0 - initial release
// ============================================================================
module morse_decoder #(
   parameter int GAP_END = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       morse_in,
   output logic [2:0] letter_out,
   output logic       letter_valid,
   output logic       error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MARK  = 2'd1,
      S_SPACE = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   localparam logic [2:0] GAP = 3'(GAP_END);

   state_t     state_q;
   logic [2:0] run_q;
   logic [2:0] zcnt_q;
   logic [3:0] elem_q;
   logic [2:0] ecnt_q;
   logic [2:0] letter_q;
   logic       valid_q;
   logic       err_q;
   logic [3:0] dec_d;

   // Returns {hit, code}; unused element bits are zero because elem is
   // cleared at the start of every letter.
   function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] e);
      case ({n, e})
         {3'd2, 4'b0010}: decode = {1'b1, 3'd0};
         {3'd4, 4'b0001}: decode = {1'b1, 3'd1};
         {3'd4, 4'b0101}: decode = {1'b1, 3'd2};
         {3'd3, 4'b0001}: decode = {1'b1, 3'd3};
         {3'd1, 4'b0000}: decode = {1'b1, 3'd4};
         {3'd4, 4'b0100}: decode = {1'b1, 3'd5};
         {3'd3, 4'b0011}: decode = {1'b1, 3'd6};
         {3'd4, 4'b0000}: decode = {1'b1, 3'd7};
         default:         decode = 4'b0000;
      endcase
   endfunction

   assign dec_d = decode(ecnt_q, elem_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         run_q    <= 3'd0;
         zcnt_q   <= 3'd0;
         elem_q   <= 4'd0;
         ecnt_q   <= 3'd0;
         letter_q <= 3'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (tick) begin
            case (state_q)
               S_IDLE: begin
                  if (morse_in) begin
                     state_q <= S_MARK;
                     run_q   <= 3'd1;
                     ecnt_q  <= 3'd0;
                     elem_q  <= 4'd0;
                  end
               end
               S_MARK: begin
                  if (morse_in) begin
                     if (run_q != 3'd4) run_q <= run_q + 3'd1;
                  end else if ((run_q == 3'd1 || run_q == 3'd3) && ecnt_q != 3'd4) begin
                     elem_q[ecnt_q[1:0]] <= (run_q == 3'd3);
                     ecnt_q  <= ecnt_q + 3'd1;
                     zcnt_q  <= 3'd1;
                     state_q <= S_SPACE;
                  end else begin
                     // The terminating space unit counts toward the flush gap.
                     err_q   <= 1'b1;
                     zcnt_q  <= 3'd1;
                     state_q <= S_FLUSH;
                  end
               end
               S_SPACE: begin
                  if (morse_in) begin
                     run_q   <= 3'd1;
                     state_q <= S_MARK;
                  end else begin
                     zcnt_q <= zcnt_q + 3'd1;
                     if (zcnt_q + 3'd1 == GAP) begin
                        state_q <= S_IDLE;
                        if (dec_d[3]) begin
                           valid_q  <= 1'b1;
                           letter_q <= dec_d[2:0];
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  if (morse_in) begin
                     zcnt_q <= 3'd0;
                  end else begin
                     zcnt_q <= zcnt_q + 3'd1;
                     if (zcnt_q + 3'd1 == GAP) state_q <= S_IDLE;
                  end
               end
            endcase
         end
      end
   end

   assign letter_out   = letter_q;
   assign letter_valid = valid_q;
   assign error        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
// Module     : tb_morse_decoder
// Description: Self-checking bench for morse_decoder; unit streams are built
//              from letter strings with expected pulses attached per tick.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_morse_decoder;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       morse_in;
   logic [2:0] letter_out;
   logic       letter_valid;
   logic       error;

   always #5 clk = ~clk;

   morse_decoder #(.GAP_END(G)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .morse_in    (morse_in),
      .letter_out  (letter_out),
      .letter_valid(letter_valid),
      .error       (error)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Per-unit stream: line level, expected event (0 none, 1 letter, 2 error), letter code.
   bit         u_q[$];
   int         ev_q[$];
   logic [2:0] lt_q[$];
   logic [2:0] exp_letter;

   string code_tab[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
   string bad_tab[8]  = '{"-", "..", "---", "-.", ".-.", "--", "...-", "-..-"};
   string pre_tab[4]  = '{"", ".", "-", "-."};
   string mk_tab[3]   = '{"2", "4", "5"};

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int mlen(input byte c);
      case (c)
         ".":     return 1;
         "-":     return 3;
         "2":     return 2;
         "4":     return 4;
         default: return 5;
      endcase
   endfunction

   task automatic push(input bit u, input int ev, input logic [2:0] l);
      u_q.push_back(u);
      ev_q.push_back(ev);
      lt_q.push_back(l);
   endtask

   // Appends a letter and its closing gap. A malformed mark (last element)
   // or a fifth element errors on the first space; an unknown pattern errors
   // at letter end.
   task automatic add_letter(input string s);
      int idx = -1;
      bit elem_err;
      for (int i = 0; i < s.len(); i++) begin
         if (i > 0) push(1'b0, 0, 3'd0);
         repeat (mlen(s[i])) push(1'b1, 0, 3'd0);
      end
      elem_err = (s.len() >= 5) || (mlen(s[s.len()-1]) inside {2, 4, 5});
      for (int i = 0; i < 8; i++) if (code_tab[i] == s) idx = i;
      for (int j = 0; j < G; j++) begin
         int ev;
         if (elem_err)        ev = (j == 0) ? 2 : 0;
         else if (j == G - 1) ev = (idx >= 0) ? 1 : 2;
         else                 ev = 0;
         push(1'b0, ev, (idx >= 0) ? idx[2:0] : 3'd0);
      end
   endtask

   // Plays the queued units with one tick every `period` clocks; non-tick
   // cycles carry random line noise.
   task automatic play(input int period);
      for (int i = 0; i < u_q.size(); i++) begin
         for (int k = 0; k < period; k++) begin
            bit t = (k == period - 1);
            int ev = 0;
            tick     = t;
            morse_in = t ? u_q[i] : 1'($urandom);
            @(posedge clk);
            #1;
            if (t) begin
               ev = ev_q[i];
               if (ev == 1) exp_letter = lt_q[i];
            end
            chk("letter_valid", {3'd0, letter_valid}, {3'd0, ev == 1});
            chk("error", {3'd0, error}, {3'd0, ev == 2});
            chk("letter_out", {1'b0, letter_out}, {1'b0, exp_letter});
         end
      end
      u_q.delete();
      ev_q.delete();
      lt_q.delete();
   endtask

   initial begin
      rst        = 1'b1;
      tick       = 1'b0;
      morse_in   = 1'b0;
      exp_letter = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_letter_out", {1'b0, letter_out}, 4'd0);
      chk("reset_valid", {3'd0, letter_valid}, 4'd0);
      chk("reset_error", {3'd0, error}, 4'd0);
      rst = 1'b0;

      // A from 0,1,0,1,1,1,0,0
      push(1'b0, 0, 3'd0);
      add_letter(".-");
      play(1);

      // A..H back to back
      for (int i = 0; i < 8; i++) add_letter(code_tab[i]);
      play(1);

      // Two-unit mark, then E
      push(1'b0, 0, 3'd0);
      add_letter("2");
      add_letter(".");
      play(2);

      // Five dots, then D
      add_letter(".....");
      add_letter("-..");
      play(1);

      // Reset during the second element of B, then H
      add_letter("....");
      play(1);
      add_letter("-...");
      while (u_q.size() > 5) begin
         void'(u_q.pop_back());
         void'(ev_q.pop_back());
         void'(lt_q.pop_back());
      end
      play(1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midreset_letter_out", {1'b0, letter_out}, 4'd0);
      chk("midreset_valid", {3'd0, letter_valid}, 4'd0);
      chk("midreset_error", {3'd0, error}, 4'd0);
      exp_letter = 3'd0;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      tick = 1'b0;
      add_letter("....");
      play(1);

      // D with tick every 4th clock and glitches in between
      add_letter("-..");
      play(4);

      // Random mix of letters, bad patterns, bad marks and overlong letters
      repeat (40) begin
         int r;
         string s;
         repeat ($urandom_range(0, 3)) push(1'b0, 0, 3'd0);
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            s = code_tab[$urandom_range(0, 7)];
         end else if (r == 6) begin
            s = bad_tab[$urandom_range(0, 7)];
         end else if (r == 7) begin
            s = {pre_tab[$urandom_range(0, 3)], mk_tab[$urandom_range(0, 2)]};
         end else begin
            s = "";
            repeat (5) s = {s, ($urandom_range(0, 1) == 1) ? "-" : "."};
         end
         add_letter(s);
         play($urandom_range(1, 4));
      end

      tick = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver that pairs with the existing 3-bit letter encoder. It samples a one-bit light/key line once per symbol-unit strobe, measures mark and space run lengths, and assembles dots and dashes. When a letter ends, it emits the matching 3-bit code for A–H, or flags an error. It sits behind the encoder's shift-out stage, or behind a debounced optical/key input, and drives the same letter codes the encoder consumes.

## Interface
- `GAP_END`, default 2: number of consecutive space units that terminate a letter; legal range 2..7.
- `clk`  in  1: system clock; all state changes on rising edge.
- `rst`  in  1: asynchronous reset, active-high.
- `tick`  in  1: symbol-unit strobe, one `clk` cycle wide; `morse_in` is sampled only when `tick`=1.
- `morse_in`  in  1: line level; 1 = light on (mark), 0 = off (space).
- `letter_out`  out  3: decoded letter: A=000, B=001, C=010, D=011, E=100, F=101, G=110, H=111.
- `letter_valid`  out  1: one-`clk` pulse; `letter_out` is updated on the same edge.
- `error`  out  1: one-`clk` pulse on a malformed element or letter.

## Operation
- Line format:
  - dot = 1 mark unit; dash = 3 mark units.
  - Intra-letter gap = 1 space unit.
  - Letter end = `GAP_END` consecutive space units.
  - Idle space of any length is ignored.
- Registers:
  - `run` (3 bit, saturates at 4): current mark length.
  - `zcnt` (3 bit, saturates at `GAP_END`): current space length.
  - `elem` (4 bit): element buffer, dash=1, dot=0, element k stored in bit k.
  - `ecnt` (3 bit): element count.
- State machine, transitions only on `tick`=1:
  - IDLE:
    - in=1 → MARK; set `run`=1, `ecnt`=0.
    - in=0 → stay in IDLE.
  - MARK:
    - in=1 → `run`+1, saturating.
    - in=0 → classify the element:
      - `run`=1 is a dot; `run`=3 is a dash.
      - Any other `run` is an error: go to FLUSH.
      - A valid element when `ecnt`=4 (fifth element) is an error: go to FLUSH.
      - Otherwise store the element at bit `ecnt`, increment `ecnt`, set `zcnt`=1, go to SPACE.
  - SPACE:
    - in=1 → MARK with `run`=1; the letter continues.
    - in=0 → `zcnt`+1. When `zcnt` reaches `GAP_END`, decode and go to IDLE.
  - FLUSH: the error has already pulsed.
    - in=1 → `zcnt`=0.
    - in=0 → `zcnt`+1; at `GAP_END` go to IDLE.
- Decode table, by (`ecnt`, element order):
  - A = .- ; B = -... ; C = -.-. ; D = -..
  - E = . ; F = ..-. ; G = --. ; H = ....
  - Any other pattern (e.g. "-", "..", "---") → `error` pulse; `letter_out` is unchanged.
- `letter_out` holds the last valid letter between pulses.

## Timing
- Reset values:
  - state=IDLE; `letter_out`=000; `letter_valid`=0; `error`=0.
  - `run`, `zcnt`, `elem`, `ecnt` all 0.
- Reset is asynchronous and takes effect mid-letter. A partial letter is discarded and no pulse is produced.
- `letter_valid` and `error` are registered. Each asserts on the `clk` edge that samples the terminating tick and deasserts on the next edge. The two are never high together.
- Decode latency: `GAP_END` ticks after the last mark unit.
  - Element errors pulse on the tick of the first space after the bad mark.
  - Pattern errors pulse at letter end.
- Between ticks, the FSM and the pulse outputs hold. A pulse lasts one `clk` even if `tick` is held high continuously; with `tick` held high, every `clk` is a sample.
- `morse_in` changes while `tick`=0 have no effect.
- Back-to-back letters (exactly `GAP_END` zeros) decode without loss. The next letter's first mark may arrive on the tick immediately after the pulse.

## Test plan
- Reset, then feed units 0,1,0,1,1,1,0,0 with `GAP_END`=2 → one `letter_valid` pulse on the 8th tick, `letter_out`=000 (A); no `error`.
- Stream all of A..H back-to-back, each separated by exactly two zeros → eight pulses with `letter_out` = 000,001,...,111 in order; no `error`.
- Mark of 2 units (0,1,1,0,0) → `error` pulse on the first zero after the mark, no `letter_valid`; a following E (1,0,0) decodes to 100.
- Five dots (1,0 ×5 then 0) → `error` on the zero after the fifth dot; FLUSH; the next letter decodes normally.
- Assert `rst` during the second element of B → all outputs 0 immediately; a subsequent H decodes to 111 with no spurious pulse.
- `tick` every 4th `clk` with `morse_in` toggling on non-tick cycles, carrying a D → single `letter_valid`, `letter_out`=011; glitches ignored.
